// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM burst packer: burst geometry,
// address field widths and the buffered burst record.
package sdram_pkg;

  localparam int BURST_LEN = 4;
  localparam int WORD_W    = 16;
  localparam int BA_W      = 3;
  localparam int ROW_W     = 14;
  localparam int COL_W     = 9;
  localparam int ADDR_W    = BA_W + ROW_W + COL_W;
  localparam int CNT_W     = 16;

  typedef logic [BURST_LEN-1:0][WORD_W-1:0] burst_data_t;

  // Address is the linear {ba,row,col} start of the burst
  typedef struct packed {
    burst_data_t       data;
    logic [ADDR_W-1:0] addr;
  } burst_t;

  typedef enum logic {
    ST_FILL,
    ST_FLUSH
  } pack_state_e;

  // Bursts always start on a BURST_LEN-aligned column
  function automatic logic [ADDR_W-1:0] burst_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sdram_burst_packer_if.sv
// Source-side and controller-side signals of the burst packer; the packer
// takes the slave view, the source/controller side takes the master view.
interface sdram_burst_packer_if;
  import sdram_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              addr_load;
  logic [ADDR_W-1:0] start_addr;
  burst_data_t       writeData;
  logic              writeDataTrig;
  logic              writeDataClk;
  logic [BA_W-1:0]   ba;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [CNT_W-1:0]  burst_count;
  logic              busy;

  modport master (
    output in_data, in_valid, flush, addr_load, start_addr, writeDataClk,
    input  in_ready, writeData, writeDataTrig, ba, row, col, burst_count, busy
  );

  modport slave (
    input  in_data, in_valid, flush, addr_load, start_addr, writeDataClk,
    output in_ready, writeData, writeDataTrig, ba, row, col, burst_count, busy
  );

endinterface

// File: rtl/sdram_burst_fifo.sv
// Two-entry burst buffer; entry0 is always the head so the controller sees
// data straight from a register. Push and pop may occur in the same cycle.
module sdram_burst_fifo
  import sdram_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  burst_t din,
  output burst_t head,
  output logic   empty,
  output logic   full
);

  burst_t     entry0;
  burst_t     entry1;
  logic [1:0] count;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop & (count != 2'd0);
  assign push_ok = push & ((count != 2'd2) | pop_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new burst lands behind whatever remains
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/sdram_burst_packer.sv
// Packs a 16-bit word stream into 4-word SDRAM write bursts, tags each burst
// with a linear address and hands them to the controller through a 2-deep buffer.
module sdram_burst_packer
  import sdram_pkg::*;
#(
  parameter logic [WORD_W-1:0] PAD_WORD  = 16'h0000,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 26'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_burst_packer_if.slave  bus
);

  pack_state_e                      state;
  logic [1:0]                       asm_cnt;
  logic [BURST_LEN-2:0][WORD_W-1:0] asm_words;
  logic [ADDR_W-1:0]                addr_q;
  logic [CNT_W-1:0]                 burst_cnt_q;

  burst_t     fifo_din;
  burst_t     fifo_head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_push;
  logic       fifo_pop;
  logic       room;
  logic       in_ready_c;
  logic       accept;
  logic       done_word;
  logic       done_flush;
  logic [1:0] cnt_next;

  always_comb begin
    fifo_pop   = bus.writeDataClk & ~fifo_empty;
    // A pop this cycle frees a slot, so a full buffer does not stall the 4th word
    room       = ~fifo_full | fifo_pop;
    in_ready_c = (state == ST_FILL) & ~((asm_cnt == 2'd3) & ~room);
    accept     = bus.in_valid & in_ready_c;
    done_word  = accept & (asm_cnt == 2'd3);
    done_flush = (state == ST_FLUSH) & room;
    fifo_push  = done_word | done_flush;
    cnt_next   = asm_cnt + {1'b0, accept};

    fifo_din.addr = addr_q;
    for (int i = 0; i < BURST_LEN-1; i++)
      fifo_din.data[i] = (done_flush && i >= int'(asm_cnt)) ? PAD_WORD : asm_words[i];
    fifo_din.data[BURST_LEN-1] = done_flush ? PAD_WORD : bus.in_data;
  end

  // The last word of a burst goes straight to the buffer, so only three are held
  always_ff @(posedge clock) begin
    for (int i = 0; i < BURST_LEN-1; i++)
      if (accept && asm_cnt == 2'(i)) asm_words[i] <= bus.in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_FILL;
      asm_cnt     <= '0;
      addr_q      <= burst_align(BASE_ADDR);
      burst_cnt_q <= '0;
    end else begin
      if (fifo_pop) burst_cnt_q <= burst_cnt_q + CNT_W'(1);

      // A load on a completion cycle still tags that burst with the old address
      if (bus.addr_load)   addr_q <= burst_align(bus.start_addr);
      else if (fifo_push)  addr_q <= addr_q + ADDR_W'(BURST_LEN);

      case (state)
        ST_FILL: begin
          asm_cnt <= cnt_next;
          if (bus.flush && cnt_next != 2'd0) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (room) begin
            asm_cnt <= '0;
            state   <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  sdram_burst_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.in_ready      = in_ready_c;
  assign bus.writeDataTrig = ~fifo_empty;
  assign bus.writeData     = fifo_head.data;
  assign {bus.ba, bus.row, bus.col} = fifo_head.addr;
  assign bus.burst_count   = burst_cnt_q;
  assign bus.busy          = (asm_cnt != 2'd0) | ~fifo_empty;

endmodule

// File: tb/tb_sdram_burst_packer.sv
// Bench for sdram_burst_packer: directed scenarios plus a randomized run,
// checked against a queue-based model of the packer's behaviour.
module tb_sdram_burst_packer;
  import sdram_pkg::*;

  localparam logic [15:0] PAD  = 16'hDEAD;
  localparam logic [25:0] BASE = 26'd0;

  typedef struct packed {
    logic [3:0][15:0] d;
    logic [25:0]      a;
  } mb_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mb_t         mbuf[$];
  logic [15:0] masm[$];
  logic [25:0] maddr;
  logic [15:0] mcount;
  bit          mfpend;

  sdram_burst_packer_if bus();

  sdram_burst_packer #(.PAD_WORD(PAD), .BASE_ADDR(BASE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit model_ready();
    bit pop;
    bit room;
    pop  = bus.writeDataClk && (mbuf.size() > 0);
    room = (mbuf.size() < 2) || pop;
    return !mfpend && !((masm.size() == 3) && !room);
  endfunction

  task automatic model_step();
    mb_t nb;
    bit  done;
    bit  pop;
    bit  room;
    bit  acc;
    done = 0;
    nb   = '0;
    pop  = bus.writeDataClk && (mbuf.size() > 0);
    room = (mbuf.size() < 2) || pop;
    acc  = bus.in_valid && model_ready();
    if (pop) begin
      void'(mbuf.pop_front());
      mcount = mcount + 16'd1;
    end
    if (mfpend && room) begin
      for (int i = 0; i < 4; i++)
        if (i < masm.size()) nb.d[i] = masm[i];
        else                 nb.d[i] = PAD;
      done   = 1;
      mfpend = 0;
      masm.delete();
    end else begin
      if (acc) masm.push_back(bus.in_data);
      if (masm.size() == 4) begin
        for (int i = 0; i < 4; i++) nb.d[i] = masm[i];
        done = 1;
        masm.delete();
      end else if (bus.flush && masm.size() != 0 && !mfpend) begin
        mfpend = 1;
      end
    end
    if (done) begin
      nb.a = maddr;
      mbuf.push_back(nb);
    end
    if (bus.addr_load) maddr = {bus.start_addr[25:2], 2'b00};
    else if (done)     maddr = maddr + 26'd4;
  endtask

  task automatic model_reset();
    mbuf.delete();
    masm.delete();
    maddr  = BASE;
    mcount = '0;
    mfpend = 0;
  endtask

  function automatic logic [107:0] exp_obs();
    mb_t hd;
    hd = '0;
    if (mbuf.size() > 0) hd = mbuf[0];
    return {(mbuf.size() > 0) ? 1'b1 : 1'b0,
            (masm.size() != 0 || mbuf.size() != 0) ? 1'b1 : 1'b0,
            mcount, hd};
  endfunction

  function automatic logic [107:0] act_obs();
    logic [89:0] hd;
    hd = bus.writeDataTrig ? {bus.writeData, bus.ba, bus.row, bus.col} : '0;
    return {bus.writeDataTrig, bus.busy, bus.burst_count, hd};
  endfunction

  task automatic clear_inputs();
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.flush        = 1'b0;
    bus.addr_load    = 1'b0;
    bus.start_addr   = '0;
    bus.writeDataClk = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_burst();
    bus.writeDataClk = 1'b1;
    cycle();
    bus.writeDataClk = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.writeDataTrig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b expected 0", bus.writeDataTrig); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.burst_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", bus.burst_count); end
    n_checks++; if (bus.writeData !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.writeData); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.in_valid = 1'b1;
    for (int w = 0; w < 12; w++) begin
      bus.in_data = 16'(w);
      #1;
      n_checks++;
      if (bus.in_ready !== (w < 11)) begin n_fail++; $display("FAIL b2b_ready w=%0d: got %b expected %b", w, bus.in_ready, (w < 11)); end
      cycle();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (act_obs() !== exp_obs()) begin n_fail++; $display("FAIL b2b_obs: got %h expected %h", act_obs(), exp_obs()); end
    n_checks++; if (bus.writeData !== {16'd3, 16'd2, 16'd1, 16'd0}) begin n_fail++; $display("FAIL b2b_burst0: got %h expected 0003000200010000", bus.writeData); end
    n_checks++; if ({bus.ba, bus.row, bus.col} !== 26'd0) begin n_fail++; $display("FAIL b2b_addr0: got %h expected 0", {bus.ba, bus.row, bus.col}); end
    pop_burst();
    n_checks++; if (bus.writeData !== {16'd7, 16'd6, 16'd5, 16'd4}) begin n_fail++; $display("FAIL b2b_burst1: got %h expected 0007000600050004", bus.writeData); end
    n_checks++; if ({bus.ba, bus.row, bus.col} !== 26'd4) begin n_fail++; $display("FAIL b2b_addr1: got %h expected 4", {bus.ba, bus.row, bus.col}); end
    n_checks++; if (bus.writeDataTrig !== 1'b1) begin n_fail++; $display("FAIL b2b_trig_held: got %b expected 1", bus.writeDataTrig); end
    pop_burst();
    n_checks++; if ({bus.writeDataTrig, bus.busy, bus.burst_count} !== {1'b0, 1'b1, 16'd2}) begin n_fail++; $display("FAIL b2b_drained: got %h expected 10002", {bus.writeDataTrig, bus.busy, bus.burst_count}); end
  endtask

  task automatic test_single_pop();
    do_reset();
    for (int w = 0; w < 4; w++) push_word(16'(w));
    n_checks++; if (bus.writeDataTrig !== 1'b1) begin n_fail++; $display("FAIL pop_trig_up: got %b expected 1", bus.writeDataTrig); end
    pop_burst();
    n_checks++; if (bus.writeDataTrig !== 1'b0) begin n_fail++; $display("FAIL pop_trig_down: got %b expected 0", bus.writeDataTrig); end
    n_checks++; if (bus.burst_count !== 16'd1) begin n_fail++; $display("FAIL pop_count: got %h expected 1", bus.burst_count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL pop_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_flush_pad();
    logic [15:0] a;
    logic [15:0] b;
    do_reset();
    a = 16'($urandom);
    b = 16'($urandom);
    push_word(a);
    push_word(b);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== model_ready()) begin n_fail++; $display("FAIL flush_ready: got %b expected %b", bus.in_ready, model_ready()); end
    for (int k = 0; k < 8 && bus.writeDataTrig !== 1'b1; k++) cycle();
    n_checks++; if (bus.writeDataTrig !== 1'b1) begin n_fail++; $display("FAIL flush_timeout: got trig %b expected 1", bus.writeDataTrig); end
    n_checks++; if (bus.writeData !== {PAD, PAD, b, a}) begin n_fail++; $display("FAIL flush_pad: got %h expected %h", bus.writeData, {PAD, PAD, b, a}); end
    n_checks++; if (act_obs() !== exp_obs()) begin n_fail++; $display("FAIL flush_obs: got %h expected %h", act_obs(), exp_obs()); end
    pop_burst();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    cycle();
    cycle();
    n_checks++; if ({bus.writeDataTrig, bus.busy, bus.in_ready} !== 3'b001) begin n_fail++; $display("FAIL flush_empty_noop: got %b expected 001", {bus.writeDataTrig, bus.busy, bus.in_ready}); end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    bus.addr_load  = 1'b1;
    bus.start_addr = 26'h3FFFFFF;
    cycle();
    bus.addr_load  = 1'b0;
    bus.start_addr = '0;
    for (int w = 0; w < 8; w++) push_word(16'h0100 + 16'(w));
    n_checks++; if ({bus.ba, bus.row, bus.col} !== {3'd7, 14'h3FFF, 9'h1FC}) begin n_fail++; $display("FAIL wrap_addr_top: got %h expected 3fffffc", {bus.ba, bus.row, bus.col}); end
    n_checks++; if (bus.writeData !== {16'h0103, 16'h0102, 16'h0101, 16'h0100}) begin n_fail++; $display("FAIL wrap_data0: got %h", bus.writeData); end
    pop_burst();
    n_checks++; if ({bus.ba, bus.row, bus.col} !== 26'd0) begin n_fail++; $display("FAIL wrap_addr_zero: got %h expected 0", {bus.ba, bus.row, bus.col}); end
    n_checks++; if (bus.writeData !== {16'h0107, 16'h0106, 16'h0105, 16'h0104}) begin n_fail++; $display("FAIL wrap_data1: got %h", bus.writeData); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    bus.in_valid = 1'b1;
    for (int w = 0; w < 11; w++) begin
      bus.in_data = 16'($urandom);
      cycle();
    end
    bus.in_data = 16'($urandom);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b expected 0", bus.in_ready); end
    bus.writeDataClk = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b expected 1", bus.in_ready); end
    cycle();
    bus.in_valid     = 1'b0;
    bus.writeDataClk = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (act_obs() !== exp_obs()) begin n_fail++; $display("FAIL full_order k=%0d: got %h expected %h", k, act_obs(), exp_obs()); end
      pop_burst();
    end
    n_checks++; if ({bus.writeDataTrig, bus.busy, bus.burst_count} !== {1'b0, 1'b0, 16'd3}) begin n_fail++; $display("FAIL full_final: got %h expected 00003", {bus.writeDataTrig, bus.busy, bus.burst_count}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int w = 0; w < 4; w++) push_word(16'($urandom));
    pop_burst();
    for (int w = 0; w < 6; w++) push_word(16'($urandom));
    n_checks++; if ({bus.writeDataTrig, bus.busy, bus.burst_count} !== {1'b1, 1'b1, 16'd1}) begin n_fail++; $display("FAIL mid_before: got %h expected 30001", {bus.writeDataTrig, bus.busy, bus.burst_count}); end
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    n_checks++; if ({bus.writeDataTrig, bus.busy, bus.burst_count} !== 18'd0) begin n_fail++; $display("FAIL mid_in_reset: got %h expected 0", {bus.writeDataTrig, bus.busy, bus.burst_count}); end
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle();
    n_checks++; if ({bus.writeDataTrig, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL mid_after_release: got %b expected 00", {bus.writeDataTrig, bus.busy}); end
    for (int w = 0; w < 4; w++) push_word(16'($urandom));
    n_checks++; if ({bus.ba, bus.row, bus.col} !== BASE) begin n_fail++; $display("FAIL mid_base_addr: got %h expected %h", {bus.ba, bus.row, bus.col}, BASE); end
    n_checks++; if (act_obs() !== exp_obs()) begin n_fail++; $display("FAIL mid_obs: got %h expected %h", act_obs(), exp_obs()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.in_data      = 16'($urandom);
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.addr_load    = ($urandom_range(0, 63) == 0);
      bus.start_addr   = 26'($urandom);
      bus.writeDataClk = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++; if (bus.in_ready !== model_ready()) begin n_fail++; $display("FAIL rand_ready n=%0d: got %b expected %b", n, bus.in_ready, model_ready()); end
      cycle();
      n_checks++; if (act_obs() !== exp_obs()) begin n_fail++; $display("FAIL rand_obs n=%0d: got %h expected %h", n, act_obs(), exp_obs()); end
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_back_to_back();
    test_single_pop();
    test_flush_pad();
    test_addr_wrap();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_burst_packer.md
SDRAM_BURST_PACKER -- requirements
Module: sdram_burst_packer

Interface
REQ-001 SHALL have parameter PAD_WORD, 16'h0000, fill value for words padded by flush.
REQ-002 SHALL have parameter BASE_ADDR, 26'd0, linear burst address after reset.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  16  write word from source.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  packer accepts word when in_valid & in_ready.
REQ-008 SHALL have port flush  input  1  single-cycle pulse; close partial burst with padding.
REQ-009 SHALL have port addr_load  input  1  load start_addr into address counter.
REQ-010 SHALL have port start_addr  input  26  linear address {ba,row,col}; bits [1:0] ignored (forced 0).
REQ-011 SHALL have port writeData  output  4x16  burst to controller, word 0 first.
REQ-012 SHALL have port writeDataTrig  output  1  burst pending; level, held until consumed.
REQ-013 SHALL have port writeDataClk  input  1  one-cycle pulse from controller: current burst consumed.
REQ-014 SHALL have ports ba/row/col  output  3/14/9  burst start address, ba in MSBs.
REQ-015 SHALL have port burst_count  output  16  bursts consumed since reset, wraps at 2^16.
REQ-016 SHALL have port busy  output  1  any partial or buffered burst present.

Function
REQ-017 SHALL pack accepted words into a 4-word assembly register at index 0..3; 4th word completes a burst.
REQ-018 SHALL hold a 2-entry burst buffer (data + address); completed burst enters buffer on the cycle after the 4th word is accepted.
REQ-019 SHALL drive in_ready = 1 unless assembly register holds 3 words and buffer is full, or a flush is in progress.
REQ-020 SHALL drive writeDataTrig = 1 whenever buffer is non-empty; writeData/ba/row/col SHALL show the buffer head and stay stable while writeDataTrig is high.
REQ-021 SHALL pop the head on writeDataClk & writeDataTrig; next entry (if any) presented the following cycle with writeDataTrig still high; writeDataClk while writeDataTrig low SHALL be ignored.
REQ-022 SHALL support simultaneous push and pop in one cycle with no loss or duplication.
REQ-023 SHALL assign each completed burst the current address counter, then increment counter by 4 modulo 2^26 (wrap 26'h3FFFFFC -> 0).
REQ-024 SHALL on flush with 1..3 words assembled fill the remaining words with PAD_WORD and complete the burst (waiting while buffer full); flush with 0 words assembled SHALL be a no-op.
REQ-025 SHALL give addr_load effect on the next completed burst; addr_load in the same cycle as a burst completion SHALL apply to the following burst.
REQ-026 SHALL increment burst_count on each pop.
REQ-027 SHALL drive busy = (assembly count != 0) | buffer non-empty.

Reset
REQ-028 SHALL on reset clear assembly count, buffer (empty), writeDataTrig=0, writeData=0, burst_count=0, address=BASE_ADDR, in_ready=1 from first cycle after release.
REQ-029 SHALL discard any partial or buffered burst when reset asserts mid-operation; no writeDataTrig until new data.

Structure
REQ-030 SHALL place BURST_LEN=4, word width 16, address widths (3/14/9, 26) and typedef burst_t (4x16 + 26-bit addr) in shared package sdram_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module sdram_burst_fifo.

Verification
REQ-032 Push words 0..7 back-to-back from BASE_ADDR=0, controller idle -> two bursts {0,1,2,3}@0 and {4,5,6,7}@4 buffered, in_ready drops after word 10 assembled until a pop.
REQ-033 Push 0..3, pulse writeDataClk on first trig cycle -> trig falls next cycle, burst_count=1, busy=0.
REQ-034 Push 2 words (A,B), flush, PAD_WORD=16'hDEAD -> burst {A,B,DEAD,DEAD} presented.
REQ-035 addr_load start_addr=26'h3FFFFFC, push 8 words -> bursts at ba=7,row=3FFF,col=1FC then address 0.
REQ-036 Buffer full, push 4th word with simultaneous pop -> no stall on that word, order preserved.
REQ-037 Assert reset with 1 buffered burst and 2 words assembled -> trig=0, busy=0, burst_count=0; next burst starts at BASE_ADDR.
